// File: rtl/caesar_sequencer_if.sv
// Bundle of the digit input, encoder handshake, result output and error-count
// signals of caesar_sequencer; slave is the sequencer, master its environment.
interface caesar_sequencer_if;
  logic       in_valid;
  logic [3:0] in_digit;
  logic       in_accept;
  logic [3:0] enc_din;
  logic       enc_ready;
  logic [4:0] enc_s;
  logic       out_valid;
  logic [4:0] out_code;
  logic       out_err;
  logic       out_take;
  logic       err_clr;
  logic [3:0] err_count;
  logic       busy;

  modport master (
    output in_valid, in_digit, enc_s, out_take, err_clr,
    input  in_accept, enc_din, enc_ready, out_valid, out_code, out_err, err_count, busy
  );

  modport slave (
    input  in_valid, in_digit, enc_s, out_take, err_clr,
    output in_accept, enc_din, enc_ready, out_valid, out_code, out_err, err_count, busy
  );
endinterface

// File: rtl/caesar_sequencer.sv
// Queues 4-bit digits in a 4-entry FIFO, drives each valid one through an external
// encoder (setup, one-cycle strobe, capture) and holds every result until taken.
module caesar_sequencer (
  input  logic              clk,
  input  logic              reset,
  caesar_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, HOLD} state_e;

  state_e     state_q, state_d;
  logic [3:0] mem_q [4];
  logic [3:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic [3:0] enc_din_q, enc_din_d;
  logic       enc_ready_q, enc_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [4:0] out_code_q, out_code_d;
  logic       out_err_q, out_err_d;
  logic [3:0] err_count_q, err_count_d;

  logic       in_accept, push, pop, dispatch, err_inc, head_invalid;
  logic [3:0] head;

  assign in_accept    = (count_q < 3'd4);
  assign push         = bus.in_valid & in_accept;
  assign head         = mem_q[rd_ptr_q];
  assign head_invalid = head[3] & (head[2] | head[1]);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    enc_din_d   = enc_din_q;
    enc_ready_d = 1'b0;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_err_d   = out_err_q;
    pop         = 1'b0;
    dispatch    = 1'b0;
    err_inc     = 1'b0;

    unique case (state_q)
      IDLE:    dispatch = 1'b1;
      SETUP: begin
        enc_ready_d = 1'b1;
        state_d     = STROBE;
      end
      STROBE:  state_d = CAPTURE;
      CAPTURE: begin
        out_code_d  = bus.enc_s;
        out_err_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_take) begin
          out_valid_d = 1'b0;
          dispatch    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Leaving IDLE or a taken HOLD: start the next head, or short-circuit an
    // invalid digit straight to an error result without touching the encoder.
    if (dispatch) begin
      state_d = IDLE;
      if (count_q != 3'd0) begin
        pop = 1'b1;
        if (head_invalid) begin
          out_code_d  = 5'd0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          err_inc     = 1'b1;
          state_d     = HOLD;
        end else begin
          enc_din_d = head;
          state_d   = SETUP;
        end
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.in_digit;
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q + {2'b00, push} - {2'b00, pop};

    if (bus.err_clr)                           err_count_d = 4'd0;
    else if (err_inc && err_count_q != 4'hF)   err_count_d = err_count_q + 4'd1;
    else                                       err_count_d = err_count_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      enc_din_q   <= 4'd0;
      enc_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= 5'd0;
      out_err_q   <= 1'b0;
      err_count_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enc_din_q   <= enc_din_d;
      enc_ready_q <= enc_ready_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count and pointers guarantee a
  // stale entry is never read, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_accept = in_accept;
  assign bus.busy      = (state_q != IDLE) || (count_q != 3'd0);
  assign bus.enc_din   = enc_din_q;
  assign bus.enc_ready = enc_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_err   = out_err_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_caesar_sequencer.sv
// Bench for caesar_sequencer: a stub encoder, a transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_caesar_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  caesar_sequencer_if bus ();

  caesar_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Stub encoder: latches a code for enc_din while ready is strobed.
  logic [4:0] enc_tab [16] = '{5'h07, 5'h12, 5'h19, 5'h00, 5'h03, 5'h1C, 5'h0A, 5'h15,
                               5'h0E, 5'h0F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
  always @(posedge clk or negedge reset) begin
    if (!reset)             bus.enc_s <= 5'h1B;
    else if (bus.enc_ready) bus.enc_s <= enc_tab[bus.enc_din];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting digits, the age of the encoder job in
  // flight (cycles since dispatch, 0 = none) and the held result.
  int         mq[$];
  int         m_age = 0;
  bit         m_hold = 0;
  logic [3:0] m_enc_din = 4'd0;
  logic [4:0] m_code = 5'd0;
  bit         m_err = 0;
  int         m_errcnt = 0;
  bit         mdl_push, mdl_free, mdl_inc;
  int         mdl_d;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_age = 0; m_hold = 0; m_enc_din = 4'd0; m_code = 5'd0; m_err = 0; m_errcnt = 0;
    end else begin
      mdl_push = bus.in_valid && (mq.size() < 4);
      mdl_free = (m_age == 0 && !m_hold) || (m_hold && bus.out_take);
      mdl_inc  = 0;
      if (m_hold && bus.out_take) m_hold = 0;
      if (m_age == 3) begin
        m_code = enc_tab[m_enc_din]; m_err = 0; m_hold = 1; m_age = 0;
      end else if (m_age != 0) begin
        m_age++;
      end
      if (mdl_free && mq.size() != 0) begin
        mdl_d = mq.pop_front();
        if (mdl_d >= 10) begin
          m_code = 5'd0; m_err = 1; m_hold = 1; mdl_inc = 1;
        end else begin
          m_enc_din = 4'(mdl_d); m_age = 1;
        end
      end
      if (mdl_push) mq.push_back(int'(bus.in_digit));
      if (bus.err_clr)                  m_errcnt = 0;
      else if (mdl_inc && m_errcnt < 15) m_errcnt++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_in_accept", 32'(bus.in_accept), 32'(mq.size() < 4));
      check("cmp_busy",      32'(bus.busy),      32'(m_age != 0 || m_hold || mq.size() != 0));
      check("cmp_enc_ready", 32'(bus.enc_ready), 32'(m_age == 2));
      check("cmp_enc_din",   32'(bus.enc_din),   32'(m_enc_din));
      check("cmp_out_valid", 32'(bus.out_valid), 32'(m_hold));
      check("cmp_out_code",  32'(bus.out_code),  32'(m_code));
      check("cmp_out_err",   32'(bus.out_err),   32'(m_err));
      check("cmp_err_count", 32'(bus.err_count), 32'(m_errcnt));
    end
  end

  task automatic step(input bit v, input logic [3:0] d, input bit take, input bit clr);
    bus.in_valid = v; bus.in_digit = d; bus.out_take = take; bus.err_clr = clr;
    @(negedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      step(1'b0, 4'd0, 1'b0, 1'b0);
      n++;
    end
    check({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic take_result(input string tag, input logic [4:0] code, input logic err);
    wait_valid(tag);
    check({tag, "_code"}, 32'(bus.out_code), 32'(code));
    check({tag, "_err"},  32'(bus.out_err),  32'(err));
    step(1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int strobes;
    bus.in_valid = 1'b0; bus.in_digit = 4'd0; bus.out_take = 1'b0; bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_enc_ready", 32'(bus.enc_ready), 32'd0);
    check("rst_enc_din",   32'(bus.enc_din),   32'd0);
    check("rst_out_code",  32'(bus.out_code),  32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_in_accept", 32'(bus.in_accept), 32'd1);
    reset = 1'b1;
    cmp_en = 1'b1;

    // Digit 0 into an idle block, out_take held high: strobe at E2, result at E4.
    step(1'b1, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t1_e1_ready", 32'(bus.enc_ready), 32'd0);
    check("t1_e1_valid", 32'(bus.out_valid), 32'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t1_e2_ready", 32'(bus.enc_ready), 32'd1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t1_e3_ready", 32'(bus.enc_ready), 32'd0);
    check("t1_e3_valid", 32'(bus.out_valid), 32'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t1_e4_valid", 32'(bus.out_valid), 32'd1);
    check("t1_e4_code",  32'(bus.out_code),  32'h07);
    check("t1_e4_err",   32'(bus.out_err),   32'd0);
    check("t1_e4_din",   32'(bus.enc_din),   32'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t1_e5_taken", 32'(bus.out_valid), 32'd0);

    // Hold a result for 5, then queue 3, 9, 12, 0 behind it and drain in order.
    step(1'b1, 4'd5, 1'b0, 1'b0);
    wait_valid("t2_pre");
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd9, 1'b0, 1'b0);
    step(1'b1, 4'd12, 1'b0, 1'b0);
    step(1'b1, 4'd0, 1'b0, 1'b0);
    check("t2_full_accept", 32'(bus.in_accept), 32'd0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    take_result("t2_r5",  5'h1C, 1'b0);
    take_result("t2_r3",  5'h00, 1'b0);
    take_result("t2_r9",  5'h0F, 1'b0);
    take_result("t2_r12", 5'h00, 1'b1);
    take_result("t2_r0",  5'h07, 1'b0);
    check("t2_err_count", 32'(bus.err_count), 32'd1);

    // Offer 6 digits with out_take low: one reaches HOLD, four queue, 6 is refused.
    for (int k = 1; k <= 6; k++) step(1'b1, 4'(k), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0);
      check("t3_full_accept", 32'(bus.in_accept), 32'd0);
    end
    take_result("t3_r1", 5'h12, 1'b0);
    take_result("t3_r2", 5'h19, 1'b0);
    take_result("t3_r3", 5'h00, 1'b0);
    take_result("t3_r4", 5'h03, 1'b0);
    take_result("t3_r5", 5'h1C, 1'b0);
    repeat (6) step(1'b0, 4'd0, 1'b0, 1'b0);
    check("t3_no_extra", 32'(bus.out_valid), 32'd0);
    check("t3_idle",     32'(bus.busy),      32'd0);

    // Invalid digits: no strobes, saturation at 15, clear wins over increment.
    step(1'b0, 4'd0, 1'b1, 1'b1);
    check("t4_clr", 32'(bus.err_count), 32'd0);
    strobes = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 4'd15, 1'b1, 1'b0);
      if (bus.enc_ready) strobes++;
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'd0, 1'b1, 1'b0);
      if (bus.enc_ready) strobes++;
    end
    check("t4_no_strobe", 32'(strobes), 32'd0);
    check("t4_cnt15",     32'(bus.err_count), 32'd15);
    step(1'b1, 4'd15, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t4_saturate", 32'(bus.err_count), 32'd15);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'd15, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    check("t4_clr_wins", 32'(bus.err_count), 32'd0);
    repeat (3) step(1'b0, 4'd0, 1'b1, 1'b0);

    // Reset during STROBE with two digits queued, then a clean run of digit 9.
    step(1'b1, 4'd9, 1'b0, 1'b0);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b1, 4'd2, 1'b0, 1'b0);
    check("t5_in_strobe", 32'(bus.enc_ready), 32'd1);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("t5_rst_ready", 32'(bus.enc_ready), 32'd0);
    check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t5_rst_busy",  32'(bus.busy),      32'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    step(1'b1, 4'd9, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("t5_e1_ready", 32'(bus.enc_ready), 32'd0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("t5_e2_ready", 32'(bus.enc_ready), 32'd1);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("t5_e3_valid", 32'(bus.out_valid), 32'd0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("t5_e4_valid", 32'(bus.out_valid), 32'd1);
    check("t5_e4_code",  32'(bus.out_code),  32'h0F);
    step(1'b0, 4'd0, 1'b1, 1'b0);

    // Random traffic against the model, with one reset pulse in the middle.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
      end
      step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    repeat (12) step(1'b0, 4'd0, 1'b1, 1'b0);
    check("end_idle", 32'(bus.busy), 32'd0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
